// File: rtl/queue_wr_arbiter.sv
// queue_wr_arbiter: round-robin write arbiter feeding a downstream queue.
// Grants one requester per cycle while the tracked occupancy has room,
// registers the winning word toward the queue, and tracks the queue
// occupancy with an EMPTY / NOT_EMPTY / FULL state machine.
module queue_wr_arbiter #(
    parameter int DWIDTH    = 32,
    parameter int NREQ      = 4,
    parameter int Q_DEPTH   = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DWIDTH-1:0] din,
    output logic [NREQ-1:0]        gnt,
    output logic                   q_enq,
    output logic [DWIDTH-1:0]      q_din,
    input  logic                   q_full,
    input  logic                   q_deq,
    output logic [CNT_WIDTH-1:0]   occupancy,
    output logic                   cnt_empty,
    output logic                   cnt_full,
    output logic                   udf_err
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        EMPTY,
        NOT_EMPTY,
        FULL
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          idx;
    logic [PW-1:0]          win;
    logic                   grant;
    logic [NREQ-1:0]        gnt_c;
    logic                   deq_ok;
    logic [CNT_WIDTH-1:0]   occ_nxt;

    // Round-robin search starting at rr_ptr; gated off in reset and when no room.
    always_comb begin
        gnt_c = '0;
        grant = 1'b0;
        win   = '0;
        idx   = '0;
        if (rstn && (|req) && (occupancy < CNT_WIDTH'(Q_DEPTH)) && !q_full) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = rr_ptr + PW'(k);
                if (!grant && req[idx]) begin
                    grant      = 1'b1;
                    win        = idx;
                    gnt_c[idx] = 1'b1;
                end
            end
        end
    end

    assign gnt    = gnt_c;
    assign deq_ok = q_deq && (occupancy != '0);

    // Next occupancy: a grant and a valid dequeue on the same edge cancel out.
    always_comb begin
        occ_nxt = occupancy;
        case ({grant, deq_ok})
            2'b10:   occ_nxt = occupancy + 1'b1;
            2'b01:   occ_nxt = occupancy - 1'b1;
            default: occ_nxt = occupancy;
        endcase
    end

    // Arbiter pointer, enqueue register, occupancy counter and sticky underflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= '0;
            q_enq     <= 1'b0;
            q_din     <= '0;
            occupancy <= '0;
            udf_err   <= 1'b0;
        end else begin
            q_enq     <= grant;
            occupancy <= occ_nxt;
            if (grant) begin
                rr_ptr <= win + 1'b1;
                q_din  <= din[int'(win)*DWIDTH +: DWIDTH];
            end
            if (q_deq && (occupancy == '0)) begin
                udf_err <= 1'b1;
            end
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state follows the next occupancy value; flags decode the current state.
    always_comb begin
        state_nxt = state;
        cnt_empty = 1'b0;
        cnt_full  = 1'b0;
        case (state)
            EMPTY: begin
                cnt_empty = 1'b1;
                if (occ_nxt == CNT_WIDTH'(Q_DEPTH)) begin
                    state_nxt = FULL;
                end else if (occ_nxt != '0) begin
                    state_nxt = NOT_EMPTY;
                end
            end
            NOT_EMPTY: begin
                if (occ_nxt == '0) begin
                    state_nxt = EMPTY;
                end else if (occ_nxt == CNT_WIDTH'(Q_DEPTH)) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                cnt_full = 1'b1;
                if (occ_nxt == '0) begin
                    state_nxt = EMPTY;
                end else if (occ_nxt != CNT_WIDTH'(Q_DEPTH)) begin
                    state_nxt = NOT_EMPTY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

endmodule

// File: doc/queue_wr_arbiter.md
QUEUE_WR_ARBITER -- requirements
Module: queue_wr_arbiter

Interface
REQ-001 Parameter DWIDTH, default 32, SHALL set the width of every data word.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters; only NREQ=4 is supported.
REQ-003 Parameter Q_DEPTH, default 8, SHALL set the capacity of the downstream queue in entries.
REQ-004 Parameter CNT_WIDTH, default 4, SHALL set the occupancy counter width; it must hold 0..Q_DEPTH.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 req  input  NREQ  SHALL carry per-requester write requests, one bit per requester.
REQ-008 din  input  NREQ*DWIDTH  SHALL carry requester data; requester i occupies bits [i*DWIDTH +: DWIDTH].
REQ-009 gnt  output  NREQ  SHALL be a combinational one-hot grant; gnt[i]=1 means din slice i is accepted at this edge.
REQ-010 q_enq  output  1  SHALL be the registered enqueue strobe to the queue.
REQ-011 q_din  output  DWIDTH  SHALL be the registered data to the queue.
REQ-012 q_full  input  1  SHALL be the queue full flag.
REQ-013 q_deq  input  1  SHALL be the dequeue strobe presented to the queue by its consumer.
REQ-014 occupancy  output  CNT_WIDTH  SHALL report the tracked entry count.
REQ-015 cnt_empty, cnt_full  output  1 each  SHALL reflect the occupancy state machine.
REQ-016 udf_err  output  1  SHALL be a sticky flag for dequeue while the tracked count is 0.

Function
REQ-017 Grant is allowed only when at least one req bit is set, occupancy < Q_DEPTH and q_full=0.
REQ-018 The arbiter SHALL use round-robin: the winner is the first set req bit at index rr_ptr, rr_ptr+1, ... mod NREQ.
REQ-019 After a grant to index w, rr_ptr SHALL become (w+1) mod NREQ at the same edge; with no grant, rr_ptr SHALL hold.
REQ-020 At most one gnt bit SHALL be high per cycle; gnt SHALL be all-zero whenever REQ-017 fails.
REQ-021 On a grant edge, q_enq SHALL be 1 and q_din SHALL take the winner's din on the following cycle; otherwise q_enq SHALL be 0 and q_din SHALL hold.
REQ-022 Enqueue latency SHALL be 1 cycle from the grant edge to q_enq high.
REQ-023 A requester keeping req high after a grant SHALL be re-arbitrated normally; one grant equals one word.
REQ-024 occupancy SHALL increment by 1 on a grant edge.
REQ-025 occupancy SHALL decrement by 1 on an edge with q_deq=1 and occupancy>0.
REQ-026 On a grant and a valid dequeue at the same edge, occupancy SHALL be unchanged.
REQ-027 Dequeue at occupancy 0 SHALL leave occupancy at 0 and set udf_err; udf_err clears only on reset.
REQ-028 The state machine SHALL have three states:
- EMPTY: occupancy 0; cnt_empty=1, cnt_full=0.
- NOT_EMPTY: occupancy 1..Q_DEPTH-1; both flags 0.
- FULL: occupancy Q_DEPTH; cnt_full=1, cnt_empty=0.
REQ-029 State transitions SHALL follow the next occupancy value:
- EMPTY to NOT_EMPTY on a grant.
- NOT_EMPTY to EMPTY on 1 to 0.
- NOT_EMPTY to FULL on Q_DEPTH-1 to Q_DEPTH.
- FULL to NOT_EMPTY on a dequeue without a grant.
REQ-030 In FULL, gnt SHALL be 0 even when q_deq=1 in that cycle; grant resumes the next cycle.
REQ-031 rr_ptr arithmetic SHALL wrap modulo NREQ, so index 3 is followed by index 0.

Reset
REQ-032 While rstn=0, the block SHALL hold:
- q_enq=0, q_din=0, occupancy=0, rr_ptr=0, udf_err=0.
- state EMPTY (cnt_empty=1, cnt_full=0), and gnt all-zero.
REQ-033 Reset asserted mid-operation SHALL discard the pending q_enq immediately; the outputs of REQ-032 apply asynchronously.

Verification
REQ-034 Directed scenarios:
- req=4'b1111 held, q_deq=0 from reset -> gnt 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000 on successive cycles; then 0 with occupancy=8 and cnt_full=1.
- Only req[2]=1, din slice2=32'hA5A5_0002 -> gnt=0100 at the edge; q_enq=1 and q_din=32'hA5A5_0002 the next cycle; occupancy=1.
- occupancy=5, single req with q_deq=1 in the same cycle -> occupancy stays 5 and state stays NOT_EMPTY.
- FULL state, req=4'b0001, q_deq=1 -> gnt=0 that cycle; occupancy=7; gnt=0001 the next cycle.
- q_deq=1 at occupancy 0 -> occupancy=0 and udf_err=1, held until rstn=0.
- rstn pulled low the cycle after a grant -> q_enq=0 and occupancy=0 at once; the first grant after release goes to req[0] when req=4'b1111.
